// File: rtl/jk_excitation_encoder.sv
// Converts a requested bank value into J/K excitation for an external JK flip-flop bank,
// then checks q_fb. Define JK_TOGGLE_ENCODE_EN for toggle encoding (default: direct).
module jk_excitation_encoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] mismatch_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] enc_j, enc_k;
  logic             mismatch;

  always_comb begin
`ifdef JK_TOGGLE_ENCODE_EN
    // Changed bits toggle, unchanged bits hold; relies on q_fb seen at accept.
    enc_j = tgt ^ q_fb;
    enc_k = tgt ^ q_fb;
`else
    // Set/reset codes only: result independent of the bank's present value.
    enc_j = tgt;
    enc_k = ~tgt;
`endif
  end

  assign mismatch = (q_fb != tgt_q);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_d   = tgt;
          j_d     = enc_j;
          k_d     = enc_k;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        done_d  = 1'b1;
        err_d   = mismatch;
        if (mismatch && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tgt_ready    = (state_q == IDLE);
  assign j            = j_q;
  assign k            = k_q;
  assign done         = done_q;
  assign err          = err_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_jk_excitation_encoder.sv
// Randomized self-checking bench for jk_excitation_encoder driving a behavioural 4-bit JK bank.
module tb_jk_excitation_encoder;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  tgt;
  logic          tgt_valid;
  logic          tgt_ready;
  logic [W-1:0]  q_fb;
  logic [W-1:0]  j, k;
  logic          done, err;
  logic [CW-1:0] mismatch_cnt;

  logic [W-1:0]  bank = '0;
  logic [W-1:0]  fault_mask = '0;
  int            cycle = 0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state of the encoder as seen from outside.
  int            exp_cnt = 0;
  bit            exp_err = 1'b0;
  int            prev_acc = 0;
  int            last_acc = 0;

  jk_excitation_encoder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .tgt          (tgt),
    .tgt_valid    (tgt_valid),
    .tgt_ready    (tgt_ready),
    .q_fb         (q_fb),
    .j            (j),
    .k            (k),
    .done         (done),
    .err          (err),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  // Bank of JK flip-flops: Q+ = J&~Q | ~K&Q, with an optional stuck-at-0 fault on readback.
  always @(posedge clk) bank <= (j & ~bank) | (~k & bank);
  assign q_fb = bank & ~fault_mask;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_txn(input logic [W-1:0] t, input bit keep_valid);
    int waited;
    logic [W-1:0] q_acc, ej, ek, eq;
    waited = 0;
    while (!tgt_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_accept", {31'd0, tgt_ready}, 32'd1);
    tgt       = t;
    tgt_valid = 1'b1;
    q_acc     = q_fb;
`ifdef JK_TOGGLE_ENCODE_EN
    ej = t ^ q_acc;
    ek = t ^ q_acc;
`else
    ej = t;
    ek = ~t;
`endif
    @(posedge clk);
    @(negedge clk);
    prev_acc = last_acc;
    last_acc = cycle;
    if (!keep_valid) tgt_valid = 1'b0;
    check("drive_j", {28'd0, j}, {28'd0, ej});
    check("drive_k", {28'd0, k}, {28'd0, ek});
    check("drive_ready", {31'd0, tgt_ready}, 32'd0);
    check("drive_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    eq = t & ~fault_mask;
    check("check_jk_hold", {24'd0, j, k}, 32'd0);
    check("check_ready", {31'd0, tgt_ready}, 32'd0);
    check("check_done", {31'd0, done}, 32'd0);
    check("check_qfb", {28'd0, q_fb}, {28'd0, eq});
    @(negedge clk);
    exp_err = (eq != t);
    if (exp_err && exp_cnt < 255) exp_cnt++;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_err", {31'd0, err}, {31'd0, exp_err});
    check("done_cnt", {24'd0, mismatch_cnt}, exp_cnt);
    check("done_ready", {31'd0, tgt_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    tgt       = '0;
    tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, tgt_ready}, 32'd1);
    check("rst_jk", {24'd0, j, k}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cnt", {24'd0, mismatch_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold start, then back-to-back with tgt_valid held high.
    run_txn(4'b1010, 1'b1);
    run_txn(4'b0110, 1'b0);
    check("b2b_spacing", last_acc - prev_acc, 32'd3);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    // Target equal to the current bank value.
    run_txn(4'b0110, 1'b0);

    // Known starting state for the toggle case.
    run_txn(4'b1100, 1'b0);
`ifdef JK_TOGGLE_ENCODE_EN
    tgt = 4'b1010;
    tgt_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    check("toggle_jk", {24'd0, j, k}, {24'd0, 4'b0110, 4'b0110});
    repeat (2) @(negedge clk);
    check("toggle_err", {31'd0, err}, 32'd0);
`else
    run_txn(4'b1010, 1'b0);
`endif

    // Random targets, random back-to-back and idle gaps.
    for (int i = 0; i < 40; i++) begin
      bit kv;
      int gap;
      kv = 1'($urandom_range(0, 1));
      run_txn(4'($urandom), kv);
      if (!kv) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("idle_done", {31'd0, done}, 32'd0);
          check("idle_err_hold", {31'd0, err}, {31'd0, exp_err});
        end
      end
    end
    tgt_valid = 1'b0;
    @(negedge clk);

    // Stuck-at-0 readback fault: drive the counter to saturation and one beyond.
    fault_mask = 4'b0001;
    while (exp_cnt < 255) run_txn(4'b0001, 1'b0);
    run_txn(4'b0001, 1'b0);
    check("sat_cnt", {24'd0, mismatch_cnt}, 32'd255);
    fault_mask = '0;
    run_txn(4'b0011, 1'b0);
    check("post_fault_err", {31'd0, err}, 32'd0);

    // Reset during DRIVE aborts the transaction.
    tgt = 4'b0101;
    tgt_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    check("midrst_jk", {24'd0, j, k}, 32'd0);
    check("midrst_ready", {31'd0, tgt_ready}, 32'd1);
    check("midrst_cnt", {24'd0, mismatch_cnt}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end
    run_txn(4'b1001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
